elevator_controller_nfloor: RTL

Parametrised successor to the two-floor elevator controller, serving NUM_FLOORS landings with a collective (SCAN) policy. Hall/car calls are latched in a pending vector. The car keeps its travel direction while calls remain ahead, and opens the door for a timed dwell at each served floor. It sits between the call-button panel and the motor/door drivers.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/elevator_door_timer.sv | 41 ++++
 rtl/elevator_controller_nfloor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings for the N-floor collective elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_door_timer.sv
// Door dwell down-counter: load/hold reload it to CYCLES-1, done flags zero.
module elevator_door_timer #(
    parameter int CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic hold,
    output logic done
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload takes priority, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load || hold) begin
            cnt_d = RELOAD;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/elevator_controller_nfloor.sv
// Collective (SCAN) elevator controller for NUM_FLOORS landings with timed door dwell.
module elevator_controller_nfloor
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS  = 4,
    parameter  int DOOR_CYCLES = 3,
    localparam int FLOOR_W     = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  floor_step,
    input  logic                  door_hold,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending_calls
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOT_FLOOR = {FLOOR_W{1'b0}};

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            r = r | (v[i] & (i > int'(f)));
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            r = r | (v[i] & (i < int'(f)));
        end
        return r;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        return {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic                    motor_up_q, motor_up_d;
    logic                    motor_down_q, motor_down_d;
    logic                    door_open_q, door_open_d;

    logic [NUM_FLOORS-1:0]   req_s;
    logic [NUM_FLOORS-1:0]   served_s;
    logic [FLOOR_W-1:0]      floor_up_s, floor_dn_s;
    logic                    above_s, below_s, here_s;
    logic                    scan_up_s, scan_down_s;
    logic                    timer_load_s, timer_hold_s, timer_done_s;

    assign req_s       = pending_q | call_req;
    assign above_s     = any_above(req_s, floor_q);
    assign below_s     = any_below(req_s, floor_q);
    assign here_s      = req_s[floor_q];
    assign floor_up_s  = floor_q + FLOOR_W'(1);
    assign floor_dn_s  = floor_q - FLOOR_W'(1);
    // Keep the preferred direction while calls lie ahead, otherwise reverse.
    assign scan_up_s   = above_s & (dir_q | ~below_s);
    assign scan_down_s = below_s & (~dir_q | ~above_s);

    elevator_door_timer #(.CYCLES(DOOR_CYCLES)) u_door_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load_s),
        .hold (timer_hold_s),
        .done (timer_done_s)
    );

    // Next-state, position, direction and served-floor mask.
    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        dir_d        = dir_q;
        served_s     = {NUM_FLOORS{1'b0}};
        timer_load_s = 1'b0;
        timer_hold_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (here_s) begin
                    state_d      = ST_DOOR_OPEN;
                    served_s     = onehot(floor_q);
                    timer_load_s = 1'b1;
                end else if (scan_up_s) begin
                    state_d = ST_MOVE_UP;
                    dir_d   = DIR_UP;
                end else if (scan_down_s) begin
                    state_d = ST_MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE_UP: begin
                if (floor_step && (floor_q != TOP_FLOOR)) begin
                    floor_d = floor_up_s;
                    if (req_s[floor_up_s] || (floor_up_s == TOP_FLOOR)) begin
                        state_d      = ST_DOOR_OPEN;
                        served_s     = onehot(floor_up_s);
                        timer_load_s = 1'b1;
                    end else begin
                        state_d = ST_MOVE_UP;
                    end
                end else begin
                    state_d = ST_MOVE_UP;
                end
            end
            ST_MOVE_DOWN: begin
                if (floor_step && (floor_q != BOT_FLOOR)) begin
                    floor_d = floor_dn_s;
                    if (req_s[floor_dn_s] || (floor_dn_s == BOT_FLOOR)) begin
                        state_d      = ST_DOOR_OPEN;
                        served_s     = onehot(floor_dn_s);
                        timer_load_s = 1'b1;
                    end else begin
                        state_d = ST_MOVE_DOWN;
                    end
                end else begin
                    state_d = ST_MOVE_DOWN;
                end
            end
            ST_DOOR_OPEN: begin
                // Calls at the open floor are absorbed and extend the dwell.
                served_s     = onehot(floor_q);
                timer_hold_s = door_hold | call_req[floor_q];
                if (!timer_hold_s && timer_done_s) begin
                    if (scan_up_s) begin
                        state_d = ST_MOVE_UP;
                        dir_d   = DIR_UP;
                    end else if (scan_down_s) begin
                        state_d = ST_MOVE_DOWN;
                        dir_d   = DIR_DOWN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DOOR_OPEN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pending_d    = (pending_q | call_req) & ~served_s;
        motor_up_d   = (state_d == ST_MOVE_UP);
        motor_down_d = (state_d == ST_MOVE_DOWN);
        door_open_d  = (state_d == ST_DOOR_OPEN);
    end

    // State, position and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            floor_q      <= {FLOOR_W{1'b0}};
            dir_q        <= DIR_UP;
            pending_q    <= {NUM_FLOORS{1'b0}};
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            dir_q        <= dir_d;
            pending_q    <= pending_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
        end
    end

    assign motor_up      = motor_up_q;
    assign motor_down    = motor_down_q;
    assign door_open     = door_open_q;
    assign current_floor = floor_q;
    assign dir_up        = dir_q;
    assign pending_calls = pending_q;

endmodule
